// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
//
// Bytes handed over on vld_tx/rdy_tx are queued in a small FIFO and sent
// LSB first on txd. Frame: start bit (0), d[0]..d[7], optional even parity,
// stop bit (1). Each bit lasts DIV = CLK_HZ/BAUD clock cycles. Frames leave
// back to back with no idle gap while the FIFO holds data.
//
// Configuration macro: UART_TX_PARITY_EN -- when defined, an even-parity bit
// is inserted between d[7] and the stop bit (11-bit frame).
//
// Parameters:
//   CLK_HZ      clock frequency in Hz
//   BAUD        line rate; DIV = CLK_HZ/BAUD (truncated) must be >= 2
//   FIFO_DEPTH  input buffer depth, power of two in 2..16
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   vld_tx  in   d_tx holds a valid byte
//   d_tx    in   [7:0] byte to transmit
//   rdy_tx  out  FIFO can accept a byte this cycle (registered)
//   txd     out  serial line, idle high (registered)
//   busy    out  FIFO non-empty or frame in progress (registered)

module uart_tx #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_tx,
    input  logic [7:0] d_tx,
    output logic       rdy_tx,
    output logic       txd,
    output logic       busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BAUD_ZERO   = CNT_W'(0);
    localparam logic [AW:0]      OCC_FULL    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      OCC_ONE     = (AW + 1)'(1);
    localparam logic [AW:0]      OCC_ZERO    = (AW + 1)'(0);
    localparam logic [AW-1:0]    PTR_ONE     = AW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic parity_even(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    // Serializer
    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic             baud_done;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shreg;
    logic             going_quiet;

    assign fifo_empty = (count == OCC_ZERO);
    assign baud_done  = (baud_cnt == BAUD_ZERO);
    assign bit_next   = bit_idx + 3'd1;
    assign push       = vld_tx & rdy_tx;

    // Pop decision uses registered occupancy only, so a byte pushed into an
    // empty FIFO is never popped on the same edge.
    always_comb begin
        pop = 1'b0;
        if (fifo_empty) begin
            pop = 1'b0;
        end else if (state == IDLE) begin
            pop = 1'b1;
        end else if ((state == STOP) && baud_done) begin
            pop = 1'b1;
        end else begin
            pop = 1'b0;
        end
    end

    // Occupancy update; push and pop together leave it unchanged.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + OCC_ONE;
            2'b01:   count_next = count - OCC_ONE;
            default: count_next = count;
        endcase
    end

    // Block returns to quiet when nothing is queued, no frame continues and
    // nothing is being written this edge.
    always_comb begin
        going_quiet = 1'b0;
        if (fifo_empty && !push && ((state == IDLE) || ((state == STOP) && baud_done))) begin
            going_quiet = 1'b1;
        end else begin
            going_quiet = 1'b0;
        end
    end

    // FIFO data array; written only on accepted bytes, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_tx;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            count  <= OCC_ZERO;
            rdy_tx <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count  <= count_next;
            rdy_tx <= (count_next != OCC_FULL);
        end
    end

    // Serializer FSM with registered txd and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= BAUD_ZERO;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            txd      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= !going_quiet;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shreg    <= mem[rd_ptr];
                        state    <= START;
                        baud_cnt <= BAUD_RELOAD;
                        txd      <= 1'b0;
                    end
                end

                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        bit_idx  <= 3'd0;
                        baud_cnt <= BAUD_RELOAD;
                        txd      <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= parity_even(shreg);
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_next;
                            txd     <= shreg[bit_next];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        state    <= STOP;
                        baud_cnt <= BAUD_RELOAD;
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
`endif

                STOP: begin
                    if (baud_done) begin
                        // Chain straight into the next frame when data waits.
                        if (!fifo_empty) begin
                            shreg    <= mem[rd_ptr];
                            state    <= START;
                            baud_cnt <= BAUD_RELOAD;
                            txd      <= 1'b0;
                        end else begin
                            state <= IDLE;
                            txd   <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int FD = FRAME * DIV;

    logic       clk;
    logic       rst;
    logic       vld_tx;
    logic [7:0] d_tx;
    logic       rdy_tx;
    logic       txd;
    logic       busy;

    logic       vld2;
    logic [7:0] d2;
    logic       rdy2;
    logic       txd2;
    logic       busy2;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [7:0] sb_q[$];

    uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .vld_tx(vld_tx), .d_tx(d_tx),
        .rdy_tx(rdy_tx), .txd(txd), .busy(busy)
    );

    uart_tx #(.CLK_HZ(200000), .BAUD(100000), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .vld_tx(vld2), .d_tx(d2),
        .rdy_tx(rdy2), .txd(txd2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // [0]=start, [8:1]=data, [9]=stop
        logic       par;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy_low(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within %0d cycles", bound);
        end
    endtask

    // Writes num bytes (base, base+1, ...) with vld_tx held; returns cycles used.
    task automatic push_bytes(input logic [7:0] base, input int num, output int n);
        int idx;
        logic acc;
        idx = 0;
        n = 0;
        while (idx < num && n < 50) begin
            d_tx = base + 8'(idx);
            vld_tx = 1'b1;
            acc = rdy_tx;
            tick();
            n++;
            if (acc) idx++;
        end
        vld_tx = 1'b0;
    endtask

    // Accept snooper: every byte the DUT takes becomes an expected frame.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && vld_tx && rdy_tx) begin
                sb_q.push_back(d_tx);
                acc_cnt++;
            end
        end
    end

    // Line monitor: decodes frames mid-bit and checks them against the queue.
    initial begin
        logic        prev;
        logic        active;
        int          mcnt;
        int          k;
        logic [10:0] mbits;
        logic [10:0] expf;
        logic [7:0]  e;
        prev = 1'b1;
        active = 1'b0;
        mcnt = 0;
        mbits = 11'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    if (prev && !txd) begin
                        active = 1'b1;
                        mcnt = 0;
                        mbits = 11'd0;
                    end
                end else begin
                    mcnt++;
                end
                if (active && (mcnt % DIV) == DIV / 2) begin
                    k = mcnt / DIV;
                    mbits[k] = txd;
                    if (k == FRAME - 1) begin
                        active = 1'b0;
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_unexpected_frame: got frame %0h expected none", mbits);
                        end else begin
                            e = sb_q.pop_front();
`ifdef UART_TX_PARITY_EN
                            expf = {1'b1, ^e, e, 1'b0};
`else
                            expf = {1'b0, 1'b1, e, 1'b0};
`endif
                            check("sb_frame", 32'(mbits), 32'(expf));
                        end
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int z;
        int bad;
        int acc0;
        logic [10:0] expf;

        vecs[0] = '{data: 8'h55, frame: 10'h2AA, par: 1'b0};
        vecs[1] = '{data: 8'h00, frame: 10'h200, par: 1'b0};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE, par: 1'b0};
        vecs[3] = '{data: 8'h80, frame: 10'h300, par: 1'b1};
        vecs[4] = '{data: 8'h01, frame: 10'h202, par: 1'b1};
        vecs[5] = '{data: 8'hA5, frame: 10'h34A, par: 1'b0};
        vecs[6] = '{data: 8'h07, frame: 10'h20E, par: 1'b1};

        rst = 1'b1;
        vld_tx = 1'b0;
        d_tx = 8'h00;
        vld2 = 1'b0;
        d2 = 8'h00;
        repeat (3) tick();
        check("rst_txd", txd, 1);
        check("rst_rdy", rdy_tx, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("idle_txd", txd, 1);
        check("idle_busy", busy, 0);

        // Table: single frames, line checked cycle by cycle
        for (int i = 0; i < 7; i++) begin
`ifdef UART_TX_PARITY_EN
            expf = {1'b1, vecs[i].par, vecs[i].frame[8:0]};
`else
            expf = {1'b0, vecs[i].frame};
`endif
            d_tx = vecs[i].data;
            vld_tx = 1'b1;
            tick();
            vld_tx = 1'b0;
            check("accept_edge_txd", txd, 1);
            for (int b = 0; b < FRAME; b++) begin
                bad = 0;
                for (int c = 0; c < DIV; c++) begin
                    tick();
                    if (txd !== expf[b]) bad++;
                end
                check($sformatf("vec%0d_bit%0d_bad_cycles", i, b), bad, 0);
            end
            tick();
            check("frame_end_busy", busy, 0);
            check("frame_end_txd", txd, 1);
        end

        // Five back-to-back writes: FIFO fills, frames chain with no gap
        push_bytes(8'h31, 5, n);
        check("b2b_cycles", n, 5);
        check("b2b_rdy_full", rdy_tx, 0);
        wait_busy_low(2000, n);
        check("b2b_duration", n, 5 * FD - 3);

        // Full FIFO with 0xAA held: taken exactly once after rdy_tx rises
        push_bytes(8'h41, 5, n);
        check("full_rdy", rdy_tx, 0);
        acc0 = acc_cnt;
        d_tx = 8'hAA;
        vld_tx = 1'b1;
        z = 0;
        while (!rdy_tx && z < 500) begin
            tick();
            z++;
        end
        check("rdy_rise_delay", z, FD - 3);
        check("no_write_while_full", acc_cnt - acc0, 0);
        tick();
        vld_tx = 1'b0;
        check("aa_accept_once", acc_cnt - acc0, 1);
        check("refull_rdy", rdy_tx, 0);
        wait_busy_low(2000, n);
        check("full_duration", n, 5 * FD - 1);

        // Reset mid-frame during DATA bit 3 of 0xF0 with two bytes queued
        push_bytes(8'hF0, 3, n);
        repeat (4 * DIV + 4) tick();
        check("f0_bit3_low", txd, 0);
        rst = 1'b1;
        #1;
        check("abort_txd", txd, 1);
        check("abort_busy", busy, 0);
        check("abort_rdy", rdy_tx, 1);
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 3 * FD; c++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no_residual_frames", bad, 0);
        d_tx = 8'h3C;
        vld_tx = 1'b1;
        tick();
        vld_tx = 1'b0;
        tick();
        check("post_rst_start", txd, 0);
        wait_busy_low(500, n);
        check("post_rst_duration", n, FD);

        // DIV=2 instance, byte 0x80: 16 low cycles then d[7] high
        d2 = 8'h80;
        vld2 = 1'b1;
        check("div2_rdy", rdy2, 1);
        tick();
        vld2 = 1'b0;
        tick();
        z = 0;
        while (txd2 === 1'b0 && z < 40) begin
            z++;
            tick();
        end
        check("div2_low_cycles", z, 16);
        check("div2_bit7", txd2, 1);
        n = 0;
        while (busy2 && n < 100) begin
            tick();
            n++;
        end
        check("div2_remaining", n, 2 * FRAME - 16);

        repeat (5) tick();
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, SHALL be the clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL be the line rate; bit period DIV = CLK_HZ/BAUD, truncated, legal range DIV >= 2.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL be the input buffer depth; power of two, range 2..16.
REQ-004 clk  input  1  SHALL be the rising-edge clock.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 vld_tx  input  1  SHALL mean the upstream byte on d_tx is valid.
REQ-007 d_tx  input  8  SHALL be the byte to transmit.
REQ-008 rdy_tx  output  1  SHALL mean the FIFO can accept a byte this cycle.
REQ-009 txd  output  1  SHALL be the serial line; idle high.
REQ-010 busy  output  1  SHALL mean the FIFO is non-empty or a frame is in progress.

Function
REQ-011 A byte SHALL be accepted on each rising edge where vld_tx=1 and rdy_tx=1; vld_tx=1 with rdy_tx=0 SHALL write nothing.
REQ-012 rdy_tx SHALL be 1 exactly when FIFO occupancy < FIFO_DEPTH, from registered occupancy only; it SHALL NOT depend combinationally on vld_tx.
REQ-013 The FIFO SHALL be first-in first-out; read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be an explicit counter of width log2(FIFO_DEPTH)+1.
REQ-014 Serializer states SHALL be IDLE, START, DATA, STOP; PARITY is added only per REQ-026.
REQ-015 IDLE: txd=1; if the FIFO is non-empty, pop the head byte into the shift register and go to START on the same edge.
REQ-016 START: txd=0 for DIV cycles, then go to DATA.
REQ-017 DATA: send d[0] first through d[7], each for DIV cycles; a 3-bit bit counter SHALL select the bit; after bit 7, go to STOP.
REQ-018 STOP: txd=1 for DIV cycles; on its last cycle, pop the next byte if the FIFO is non-empty and go to START (no idle gap), else go to IDLE.
REQ-019 The baud counter SHALL reload to DIV-1 on every state entry and count down to 0; each bit SHALL last exactly DIV clk cycles.
REQ-020 txd SHALL be driven from a register; it SHALL fall at the first clk edge after the accepting edge of a byte written into an empty, idle block.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged and SHALL be legal at any occupancy below FIFO_DEPTH.
REQ-022 A push into an empty FIFO SHALL NOT be popped on the same edge.
REQ-023 When full, a pop SHALL raise rdy_tx on the following cycle.

Reset
REQ-024 While rst=1: txd=1, rdy_tx=1, busy=0, state=IDLE, FIFO empty, counters cleared.
REQ-025 rst asserted mid-frame SHALL abort the frame immediately (txd=1 asynchronously) and discard all buffered bytes; the first byte after release SHALL be framed normally.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined: state PARITY is inserted between DATA and STOP, txd = XOR of d[7:0] (even parity) for DIV cycles, frame = 11 bits.
REQ-027 With UART_TX_PARITY_EN undefined: no parity state or logic, frame = 10 bits.

Verification (CLK_HZ=1000000, BAUD=100000, DIV=10)
REQ-028 Single byte 0x55 into idle block -> txd low 1 cycle after accept; line pattern 0,1,0,1,0,1,0,1,0,1, each for 10 cycles; busy drops after 100 cycles (110 with parity, parity bit 0).
REQ-029 Five back-to-back writes 0x31..0x35 with vld_tx held high -> rdy_tx=0 after occupancy reaches 4; all five frames sent in order with no idle gap.
REQ-030 Full FIFO, vld_tx=1 with 0xAA until a pop -> 0xAA accepted exactly once, on the edge after rdy_tx rises.
REQ-031 rst pulse during DATA bit 3 of 0xF0 with 2 bytes queued -> txd=1 at once; busy=0; no residual frames after release.
REQ-032 Parity build, byte 0x07 -> parity bit 1, 11-bit frame of 110 cycles.
REQ-033 DIV=2 (CLK_HZ=200000) with byte 0x80 -> every bit is 2 cycles; only d[7] is high, so txd is 0 for 16 cycles (start plus d[0]..d[6]), then 1.
